// File: rtl/pet_status.sv
// Pet mood tracker: on each tick, samples six need levels and updates mood, worst need,
// critical-tick counter, age and a one-cycle alert on entry to the critical mood.
module pet_status #(
    parameter int unsigned WARN_LVL    = 8,
    parameter int unsigned CRIT_LVL    = 13,
    parameter int unsigned SLEEP_LVL   = 12,
    parameter int unsigned DEATH_TICKS = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [3:0]  hunger,
    input  logic [3:0]  happiness,
    input  logic [3:0]  health,
    input  logic [3:0]  hygiene,
    input  logic [3:0]  energy,
    input  logic [3:0]  social,
    output logic [2:0]  mood,
    output logic [2:0]  worst_stat,
    output logic        alert,
    output logic [7:0]  crit_cnt,
    output logic [15:0] age
);

    typedef enum logic [2:0] {
        StHappy = 3'd0,
        StNeedy = 3'd1,
        StCrit  = 3'd2,
        StSleep = 3'd3,
        StDead  = 3'd4
    } mood_e;

    localparam logic [3:0] WarnLvl    = 4'(WARN_LVL);
    localparam logic [3:0] CritLvl    = 4'(CRIT_LVL);
    localparam logic [3:0] SleepLvl   = 4'(SLEEP_LVL);
    localparam logic [7:0] DeathTicks = 8'(DEATH_TICKS);

    mood_e       state_q, state_d;
    logic [2:0]  worst_q, worst_d;
    logic        alert_q, alert_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] age_q, age_d;

    logic [3:0]  stat [6];
    logic [3:0]  max_lvl;
    logic [2:0]  max_idx;
    logic [3:0]  other_max;
    mood_e       cls;
    logic [7:0]  cnt_inc;

    assign stat[0] = hunger;
    assign stat[1] = happiness;
    assign stat[2] = health;
    assign stat[3] = hygiene;
    assign stat[4] = energy;
    assign stat[5] = social;

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        max_lvl   = stat[0];
        max_idx   = 3'd0;
        other_max = stat[0];
        for (int i = 1; i < 6; i++) begin
            if (stat[i] > max_lvl) begin
                max_lvl = stat[i];
                max_idx = 3'(i);
            end
            if (i != 4 && stat[i] > other_max) begin
                other_max = stat[i];
            end
        end
    end

    always_comb begin
        cls = StHappy;
        if (max_lvl >= CritLvl) begin
            cls = StCrit;
        end else if (max_lvl >= WarnLvl) begin
            cls = StNeedy;
        end
    end

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        worst_d = worst_q;
        alert_d = 1'b0;
        cnt_d   = cnt_q;
        age_d   = age_q;
        if (tick && state_q != StDead) begin
            worst_d = max_idx;
            if (age_q != 16'hFFFF) begin
                age_d = age_q + 16'd1;
            end
            unique case (state_q)
                StHappy, StNeedy: begin
                    if (cls == StCrit) begin
                        state_d = StCrit;
                    end else if (energy >= SleepLvl) begin
                        state_d = StSleep;
                    end else begin
                        state_d = cls;
                    end
                end
                StSleep: begin
                    if (other_max >= CritLvl) begin
                        state_d = StCrit;
                    end else if (energy == 4'd0) begin
                        state_d = cls;
                    end
                end
                StCrit: begin
                    if (cls != StCrit) begin
                        state_d = cls;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DeathTicks) begin
                            state_d = StDead;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
            if (state_d == StCrit && state_q != StCrit) begin
                alert_d = 1'b1;
                cnt_d   = 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StHappy;
            worst_q <= 3'd0;
            alert_q <= 1'b0;
            cnt_q   <= 8'd0;
            age_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            worst_q <= worst_d;
            alert_q <= alert_d;
            cnt_q   <= cnt_d;
            age_q   <= age_d;
        end
    end

    assign mood       = state_q;
    assign worst_stat = worst_q;
    assign alert      = alert_q;
    assign crit_cnt   = cnt_q;
    assign age        = age_q;

endmodule

// File: tb/tb_pet_status.sv
// Directed bench for pet_status: a tick-level mood model checked every cycle, plus literal
// expectations at the milestones of each scenario.
module tb_pet_status;

    localparam int DT = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0;
    logic [3:0]  hunger = 0, happiness = 0, health = 0, hygiene = 0, energy = 0, social = 0;
    logic [2:0]  mood, worst_stat;
    logic        alert;
    logic [7:0]  crit_cnt;
    logic [15:0] age;

    int checks = 0;
    int errors = 0;

    // Model state as plain integers: 0 happy, 1 needy, 2 critical, 3 sleep, 4 dead.
    int m_mood = 0, m_worst = 0, m_alert = 0, m_cnt = 0, m_age = 0;
    bit m_valid = 0;

    pet_status dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .hunger     (hunger),
        .happiness  (happiness),
        .health     (health),
        .hygiene    (hygiene),
        .energy     (energy),
        .social     (social),
        .mood       (mood),
        .worst_stat (worst_stat),
        .alert      (alert),
        .crit_cnt   (crit_cnt),
        .age        (age)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int s[6];
        int mx, idx, oth, cls, nm;
        if (!reset_n) begin
            m_mood = 0; m_worst = 0; m_alert = 0; m_cnt = 0; m_age = 0;
            m_valid = 1;
        end else begin
            m_alert = 0;
            if (tick && m_mood != 4) begin
                s = '{hunger, happiness, health, hygiene, energy, social};
                mx = -1; idx = 0; oth = 0;
                foreach (s[i]) begin
                    if (s[i] > mx) begin mx = s[i]; idx = i; end
                    if (i != 4 && s[i] > oth) oth = s[i];
                end
                cls = (mx >= 13) ? 2 : (mx >= 8) ? 1 : 0;
                if (m_mood == 3)      nm = (oth >= 13) ? 2 : (energy == 0) ? cls : 3;
                else if (m_mood == 2) nm = (cls != 2) ? cls : (m_cnt + 1 >= DT) ? 4 : 2;
                else                  nm = (cls == 2) ? 2 : (energy >= 12) ? 3 : cls;
                if (nm == 2 && m_mood != 2) begin
                    m_cnt = 1; m_alert = 1;
                end else if (m_mood == 2) begin
                    m_cnt = (nm == 2 || nm == 4) ? m_cnt + 1 : 0;
                end
                m_worst = idx;
                if (m_age < 65535) m_age++;
                m_mood = nm;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("mood", mood, m_mood);
            check("worst_stat", worst_stat, m_worst);
            check("alert", alert, m_alert);
            check("crit_cnt", crit_cnt, m_cnt);
            check("age", age, m_age);
        end
    end

    task automatic set_stats(input int hu, ha, he, hy, en, so);
        hunger = 4'(hu); happiness = 4'(ha); health = 4'(he);
        hygiene = 4'(hy); energy = 4'(en); social = 4'(so);
    endtask

    task automatic step(input int hu, ha, he, hy, en, so);
        @(negedge clk);
        set_stats(hu, ha, he, hy, en, so);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset(input logic t);
        @(negedge clk);
        reset_n = 1'b0;
        tick = t;
        @(negedge clk);
        reset_n = 1'b1;
        tick = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        check("reset mood", mood, 0);
        check("reset age", age, 0);
        check("reset crit_cnt", crit_cnt, 0);

        // All satisfied for five ticks.
        repeat (5) step(0, 0, 0, 0, 0, 0);
        check("idle5 mood", mood, 0);
        check("idle5 age", age, 5);
        check("idle5 worst", worst_stat, 0);

        // Hygiene warns, then goes critical.
        step(0, 0, 0, 9, 0, 0);
        check("hyg9 mood", mood, 1);
        check("hyg9 worst", worst_stat, 3);
        step(0, 0, 0, 14, 0, 0);
        check("hyg14 mood", mood, 2);
        check("hyg14 alert", alert, 1);
        check("hyg14 crit_cnt", crit_cnt, 1);
        @(negedge clk);
        check("alert drops", alert, 0);
        step(0, 0, 0, 0, 0, 0);
        check("recover mood", mood, 0);
        check("recover crit_cnt", crit_cnt, 0);

        // Ten critical health ticks kill the pet; later ticks do nothing.
        repeat (10) step(0, 0, 15, 0, 0, 0);
        check("death mood", mood, 4);
        check("death crit_cnt", crit_cnt, 10);
        check("death age", age, 18);
        repeat (3) step(15, 0, 0, 0, 0, 0);
        check("dead age frozen", age, 18);
        check("dead worst frozen", worst_stat, 2);
        check("dead mood", mood, 4);

        // Reset in DEAD with a simultaneous tick.
        do_reset(1'b1);
        check("rst dead mood", mood, 0);
        check("rst dead age", age, 0);
        check("rst dead crit_cnt", crit_cnt, 0);
        check("rst dead alert", alert, 0);

        // Sleep cycle, then woken by social need.
        step(0, 0, 0, 0, 12, 0);
        check("sleep mood", mood, 3);
        check("sleep worst", worst_stat, 4);
        step(0, 0, 0, 0, 6, 0);
        check("sleep stays", mood, 3);
        step(0, 0, 0, 0, 0, 0);
        check("wake mood", mood, 0);
        step(0, 0, 0, 0, 12, 0);
        step(0, 0, 0, 0, 12, 13);
        check("woken mood", mood, 2);
        check("woken alert", alert, 1);
        check("woken worst", worst_stat, 5);

        // Tie resolves to hunger; outputs hold without tick.
        step(10, 0, 0, 0, 0, 10);
        check("tie mood", mood, 1);
        check("tie worst", worst_stat, 0);
        repeat (100) @(negedge clk);
        check("hold mood", mood, 1);
        check("hold age", age, 6);

        // Reset mid-critical, then a normal first tick.
        step(0, 0, 15, 0, 0, 0);
        do_reset(1'b0);
        step(9, 0, 0, 0, 0, 0);
        check("post rst mood", mood, 1);
        check("post rst age", age, 1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
